// File: rtl/branch_predictor_btb.sv
// Tagged branch target buffer with saturating direction counters, zero-latency Fetch lookup,
// Execute-side mispredict detection and saturating branch/mispredict statistics.
module branch_predictor_btb #(
  parameter int NUM_ENTRIES = 16,
  parameter int CTR_W       = 2,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [31:0]      i_pc_f,
  output logic             o_hit_f,
  output logic             o_pred_taken_f,
  output logic [31:0]      o_pred_target_f,
  input  logic             i_upd_valid_e,
  input  logic [31:0]      i_upd_pc_e,
  input  logic             i_upd_is_jump_e,
  input  logic             i_upd_taken_e,
  input  logic [31:0]      i_upd_target_e,
  input  logic             i_upd_pred_taken_e,
  input  logic [31:0]      i_upd_pred_target_e,
  output logic             o_mispredict_e,
  output logic [31:0]      o_redirect_pc_e,
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_mispredict_cnt
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [CTR_W-1:0] ctr;
    logic             is_jump;
  } entry_t;

  entry_t tbl_q [NUM_ENTRIES];
  entry_t wr_entry_d;
  logic   wr_en_d;

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  entry_t           f_ent;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  entry_t           upd_ent;
  logic             upd_hit;
  logic             mispredict;

  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] misp_cnt_q, misp_cnt_d;

  // Fetch PCs are word aligned; the byte offset never reaches the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^i_pc_f[1:0];

  assign f_idx = i_pc_f[IDX_W+1:2];
  assign f_tag = i_pc_f[31:IDX_W+2];
  assign f_ent = tbl_q[f_idx];

  assign o_hit_f         = f_ent.valid && (f_ent.tag == f_tag);
  assign o_pred_taken_f  = o_hit_f && (f_ent.is_jump || f_ent.ctr[CTR_W-1]);
  assign o_pred_target_f = o_pred_taken_f ? f_ent.target : 32'd0;

  assign mispredict = i_upd_valid_e &&
                      ((i_upd_pred_taken_e != i_upd_taken_e) ||
                       (i_upd_taken_e && (i_upd_pred_target_e != i_upd_target_e)));
  assign o_mispredict_e  = mispredict;
  assign o_redirect_pc_e = !mispredict   ? 32'd0 :
                           i_upd_taken_e ? i_upd_target_e : i_upd_pc_e + 32'd4;

  assign upd_idx = i_upd_pc_e[IDX_W+1:2];
  assign upd_tag = i_upd_pc_e[31:IDX_W+2];
  assign upd_ent = tbl_q[upd_idx];
  assign upd_hit = upd_ent.valid && (upd_ent.tag == upd_tag);

  // Single write port: train on a hit, allocate only on a taken miss.
  always_comb begin
    wr_en_d    = 1'b0;
    wr_entry_d = upd_ent;
    if (i_upd_valid_e) begin
      if (upd_hit) begin
        wr_en_d = 1'b1;
        if (i_upd_taken_e) begin
          wr_entry_d.ctr     = (upd_ent.ctr == CTR_MAX) ? CTR_MAX : upd_ent.ctr + CTR_ONE;
          wr_entry_d.target  = i_upd_target_e;
          wr_entry_d.is_jump = i_upd_is_jump_e;
        end else begin
          wr_entry_d.ctr = (upd_ent.ctr == '0) ? '0 : upd_ent.ctr - CTR_ONE;
        end
      end else if (i_upd_taken_e) begin
        wr_en_d            = 1'b1;
        wr_entry_d.valid   = 1'b1;
        wr_entry_d.tag     = upd_tag;
        wr_entry_d.target  = i_upd_target_e;
        wr_entry_d.ctr     = CTR_WEAK;
        wr_entry_d.is_jump = i_upd_is_jump_e;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (wr_en_d) begin
      tbl_q[upd_idx] <= wr_entry_d;
    end
  end

  // Clear wins over increment; both counters stick at all-ones.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    misp_cnt_d   = misp_cnt_q;
    if (i_cnt_clr) begin
      branch_cnt_d = '0;
      misp_cnt_d   = '0;
    end else begin
      if (i_upd_valid_e && !(&branch_cnt_q)) begin
        branch_cnt_d = branch_cnt_q + CNT_ONE;
      end
      if (mispredict && !(&misp_cnt_q)) begin
        misp_cnt_d = misp_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      branch_cnt_q <= '0;
      misp_cnt_q   <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      misp_cnt_q   <= misp_cnt_d;
    end
  end

  assign o_branch_cnt     = branch_cnt_q;
  assign o_mispredict_cnt = misp_cnt_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb: a per-cycle reference model compare plus
// hand-computed literal checks along the stimulus sequence.
module tb_branch_predictor_btb;

  localparam int NE   = 16;
  localparam int CW   = 2;
  localparam int CNTW = 4;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic [31:0]     i_pc_f;
  logic            o_hit_f;
  logic            o_pred_taken_f;
  logic [31:0]     o_pred_target_f;
  logic            i_upd_valid_e;
  logic [31:0]     i_upd_pc_e;
  logic            i_upd_is_jump_e;
  logic            i_upd_taken_e;
  logic [31:0]     i_upd_target_e;
  logic            i_upd_pred_taken_e;
  logic [31:0]     i_upd_pred_target_e;
  logic            o_mispredict_e;
  logic [31:0]     o_redirect_pc_e;
  logic            i_cnt_clr;
  logic [CNTW-1:0] o_branch_cnt;
  logic [CNTW-1:0] o_mispredict_cnt;

  int checks   = 0;
  int failures = 0;

  branch_predictor_btb #(.NUM_ENTRIES(NE), .CTR_W(CW), .CNT_W(CNTW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pc_f(i_pc_f),
    .o_hit_f(o_hit_f), .o_pred_taken_f(o_pred_taken_f), .o_pred_target_f(o_pred_target_f),
    .i_upd_valid_e(i_upd_valid_e), .i_upd_pc_e(i_upd_pc_e), .i_upd_is_jump_e(i_upd_is_jump_e),
    .i_upd_taken_e(i_upd_taken_e), .i_upd_target_e(i_upd_target_e),
    .i_upd_pred_taken_e(i_upd_pred_taken_e), .i_upd_pred_target_e(i_upd_pred_target_e),
    .o_mispredict_e(o_mispredict_e), .o_redirect_pc_e(o_redirect_pc_e),
    .i_cnt_clr(i_cnt_clr), .o_branch_cnt(o_branch_cnt), .o_mispredict_cnt(o_mispredict_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid [NE];
  int unsigned m_tag   [NE];
  logic [31:0] m_tgt   [NE];
  int          m_ctr   [NE];
  bit          m_jump  [NE];
  int unsigned m_bcnt, m_mcnt;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'(NE));
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return int'(pc / 32'(4 * NE));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NE; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 0; m_jump[i] = 0;
    end
    m_bcnt = 0;
    m_mcnt = 0;
  endtask

  initial begin
    int          fi, ui;
    bit          e_hit, e_pred, e_misp, u_hit;
    logic [31:0] e_tgt, e_red;
    model_reset();
    forever begin
      @(negedge i_clk);
      if (i_rst) model_reset();
      fi     = idx_of(i_pc_f);
      e_hit  = m_valid[fi] && (m_tag[fi] == tag_of(i_pc_f));
      e_pred = e_hit && (m_jump[fi] || (m_ctr[fi] >= 2 ** (CW - 1)));
      e_tgt  = e_pred ? m_tgt[fi] : 32'd0;
      e_misp = i_upd_valid_e && ((i_upd_pred_taken_e != i_upd_taken_e) ||
               (i_upd_taken_e && (i_upd_pred_target_e != i_upd_target_e)));
      e_red  = !e_misp ? 32'd0 : (i_upd_taken_e ? i_upd_target_e : i_upd_pc_e + 32'd4);
      chk("model_hit", 32'(o_hit_f), 32'(e_hit));
      chk("model_pred", 32'(o_pred_taken_f), 32'(e_pred));
      chk("model_target", o_pred_target_f, e_tgt);
      chk("model_mispredict", 32'(o_mispredict_e), 32'(e_misp));
      chk("model_redirect", o_redirect_pc_e, e_red);
      chk("model_branch_cnt", 32'(o_branch_cnt), m_bcnt);
      chk("model_misp_cnt", 32'(o_mispredict_cnt), m_mcnt);
      if (!i_rst) begin
        if (i_upd_valid_e) begin
          ui    = idx_of(i_upd_pc_e);
          u_hit = m_valid[ui] && (m_tag[ui] == tag_of(i_upd_pc_e));
          if (u_hit && i_upd_taken_e) begin
            if (m_ctr[ui] < 2 ** CW - 1) m_ctr[ui]++;
            m_tgt[ui]  = i_upd_target_e;
            m_jump[ui] = i_upd_is_jump_e;
          end else if (u_hit) begin
            if (m_ctr[ui] > 0) m_ctr[ui]--;
          end else if (i_upd_taken_e) begin
            m_valid[ui] = 1;
            m_tag[ui]   = tag_of(i_upd_pc_e);
            m_tgt[ui]   = i_upd_target_e;
            m_jump[ui]  = i_upd_is_jump_e;
            m_ctr[ui]   = 2 ** (CW - 1);
          end
        end
        if (i_cnt_clr) begin
          m_bcnt = 0;
          m_mcnt = 0;
        end else begin
          if (i_upd_valid_e && m_bcnt < 2 ** CNTW - 1) m_bcnt++;
          if (e_misp && m_mcnt < 2 ** CNTW - 1) m_mcnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic nx();
    @(posedge i_clk);
    #1;
    i_upd_valid_e = 1'b0;
    i_cnt_clr     = 1'b0;
  endtask

  task automatic neg();
    @(negedge i_clk);
  endtask

  task automatic upd(input logic [31:0] pc, input logic jmp, input logic tk,
                     input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    i_upd_valid_e       = 1'b1;
    i_upd_pc_e          = pc;
    i_upd_is_jump_e     = jmp;
    i_upd_taken_e       = tk;
    i_upd_target_e      = tgt;
    i_upd_pred_taken_e  = ptk;
    i_upd_pred_target_e = ptgt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    i_rst = 1'b1; i_pc_f = '0; i_cnt_clr = 1'b0;
    upd(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    i_upd_valid_e = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;

    i_pc_f = 32'h100;
    neg();
    chk("reset_hit", 32'(o_hit_f), 32'd0);
    chk("reset_pred", 32'(o_pred_taken_f), 32'd0);
    chk("reset_target", o_pred_target_f, 32'd0);
    chk("reset_bcnt", 32'(o_branch_cnt), 32'd0);

    nx(); upd(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    neg();
    chk("alloc_misp", 32'(o_mispredict_e), 32'd1);
    chk("alloc_redirect", o_redirect_pc_e, 32'h80);
    nx(); neg();
    chk("alloc_hit", 32'(o_hit_f), 32'd1);
    chk("alloc_pred", 32'(o_pred_taken_f), 32'd1);
    chk("alloc_target", o_pred_target_f, 32'h80);

    nx(); upd(32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80);
    neg();
    chk("nt_misp", 32'(o_mispredict_e), 32'd1);
    chk("nt_redirect", o_redirect_pc_e, 32'h104);
    nx(); neg();
    chk("ctr1_hit", 32'(o_hit_f), 32'd1);
    chk("ctr1_pred", 32'(o_pred_taken_f), 32'd0);
    chk("ctr1_target", o_pred_target_f, 32'd0);

    nx(); upd(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    neg();
    chk("nt_ok_misp", 32'(o_mispredict_e), 32'd0);
    chk("nt_ok_redirect", o_redirect_pc_e, 32'd0);
    nx(); upd(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    nx(); upd(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    nx(); neg();
    chk("ctr_floor_pred", 32'(o_pred_taken_f), 32'd0);
    nx(); upd(32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    nx(); neg();
    chk("ctr2_pred", 32'(o_pred_taken_f), 32'd1);

    nx(); upd(32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 32'h84);
    neg();
    chk("tgt_mismatch_misp", 32'(o_mispredict_e), 32'd1);
    chk("tgt_mismatch_redirect", o_redirect_pc_e, 32'h80);

    nx(); upd(32'h140, 1'b0, 1'b1, 32'h90, 1'b0, 32'h0);
    nx(); neg();
    chk("alias_old_hit", 32'(o_hit_f), 32'd0);
    nx(); i_pc_f = 32'h140; neg();
    chk("alias_new_target", o_pred_target_f, 32'h90);

    nx(); upd(32'h180, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    nx(); i_pc_f = 32'h180; neg();
    chk("nt_miss_noalloc", 32'(o_hit_f), 32'd0);
    nx(); i_pc_f = 32'h140; neg();
    chk("nt_miss_keeps_old", 32'(o_hit_f), 32'd1);

    nx(); upd(32'h200, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
    nx(); upd(32'h200, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    nx(); upd(32'h200, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    nx(); i_pc_f = 32'h200; neg();
    chk("jump_pred", 32'(o_pred_taken_f), 32'd1);
    chk("jump_target", o_pred_target_f, 32'h300);

    nx(); upd(32'h240, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0);
    neg();
    chk("collide_old_hit", 32'(o_hit_f), 32'd1);
    chk("collide_old_target", o_pred_target_f, 32'h300);
    nx(); neg();
    chk("collide_replaced", 32'(o_hit_f), 32'd0);
    nx(); i_pc_f = 32'h240; neg();
    chk("collide_new_target", o_pred_target_f, 32'h400);

    nx(); i_cnt_clr = 1'b1;
    for (int k = 0; k < 10; k++) begin
      nx(); upd(32'h3000, 1'b0, 1'b0, 32'h0, (k < 3) ? 1'b1 : 1'b0, 32'h0);
    end
    nx(); neg();
    chk("stats_branch", 32'(o_branch_cnt), 32'd10);
    chk("stats_misp", 32'(o_mispredict_cnt), 32'd3);
    nx(); upd(32'h3000, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0); i_cnt_clr = 1'b1;
    nx(); neg();
    chk("clr_branch", 32'(o_branch_cnt), 32'd0);
    chk("clr_misp", 32'(o_mispredict_cnt), 32'd0);
    chk("clr_keeps_table", 32'(o_hit_f), 32'd1);

    for (int k = 0; k < 20; k++) begin
      nx(); upd(32'h3000, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    end
    nx(); neg();
    chk("sat_branch", 32'(o_branch_cnt), 32'd15);
    chk("sat_misp", 32'(o_mispredict_cnt), 32'd15);

    nx(); upd(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    neg();
    chk("wrap_misp", 32'(o_mispredict_e), 32'd1);
    chk("wrap_redirect", o_redirect_pc_e, 32'd0);

    nx(); upd(32'h500, 1'b0, 1'b1, 32'h600, 1'b0, 32'h0); i_rst = 1'b1; i_pc_f = 32'h240;
    #1;
    chk("midrst_hit", 32'(o_hit_f), 32'd0);
    chk("midrst_bcnt", 32'(o_branch_cnt), 32'd0);
    chk("midrst_mcnt", 32'(o_mispredict_cnt), 32'd0);
    nx(); i_rst = 1'b0; i_pc_f = 32'h500; neg();
    chk("rst_discards_upd", 32'(o_hit_f), 32'd0);

    nx(); neg();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
